// File: rtl/sig_echo.sv
// sig_echo: programmable-delay echo line over a circular sample RAM.
//
// A zero-fill state machine clears the RAM after reset or on i_clr, then
// accepts one signed sample per cycle. Each accepted sample produces, two
// cycles later, the sample i_offset accepted-samples earlier plus a saturated
// mix of the input and the attenuated delayed sample.
//
// Build option: define SIG_ECHO_FEEDBACK_EN for a recursive echo. The RAM then
// stores the mix, and the effective offset is clamped to at least 3.
//
// Ports:
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_clr          request to re-zero the buffer (honoured only while running)
//   i_in_valid     i_din holds a sample
//   o_in_ready     a sample is accepted this cycle when i_in_valid is high
//   i_din          input sample, signed
//   i_offset       delay in accepted samples, captured with each sample
//   i_gain_shift   arithmetic right shift applied to the delayed sample
//   o_out_valid    one-cycle strobe, outputs below are fresh
//   o_dout_delayed delayed sample
//   o_dout_mix     saturated i_din + (delayed >>> i_gain_shift)
//   o_busy         high while the buffer is being cleared
module sig_echo #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int G_WIDTH = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [D_WIDTH-1:0] i_din,
    input  logic [A_WIDTH-1:0] i_offset,
    input  logic [G_WIDTH-1:0] i_gain_shift,
    output logic               o_out_valid,
    output logic [D_WIDTH-1:0] o_dout_delayed,
    output logic [D_WIDTH-1:0] o_dout_mix,
    output logic               o_busy
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [D_WIDTH-1:0] SAT_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] SAT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [A_WIDTH-1:0] r_clr_addr, r_wr_ptr, w_rd_addr, w_eff_offset, w_wa;
    logic               w_accept, w_clr_hit, w_we;
    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [D_WIDTH-1:0] r_rd_data, w_wd, w_delayed, w_shifted, w_mix;
    logic [D_WIDTH:0]   w_sum;
    logic               r_s1_valid, r_s2_valid;
    logic [D_WIDTH-1:0] r_s1_din, r_s2_din, r_s2_delayed;
    logic [G_WIDTH-1:0] r_s1_gain, r_s2_gain;
`ifdef SIG_ECHO_FEEDBACK_EN
    logic [A_WIDTH-1:0] r_s1_addr, r_s2_addr;
`else
    logic               r_s1_fwd;
`endif

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_busy      = 1'b1;
        w_clr_hit   = 1'b0;
        if (r_state == CLEAR) begin
            if (&r_clr_addr) w_state_nxt = RUN;
        end else begin
            o_busy      = 1'b0;
            w_clr_hit   = i_clr;
            // A clear request in the same cycle takes priority over a sample.
            o_in_ready  = !i_clr;
            if (i_clr) w_state_nxt = CLEAR;
        end
    end

    assign w_accept = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
            if (w_clr_hit) begin
                r_wr_ptr   <= '0;
                r_clr_addr <= '0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

`ifdef SIG_ECHO_FEEDBACK_EN
    // The mix is written back two edges after acceptance, so a read closer
    // than 3 samples would hit a location not yet (or just now) written.
    assign w_eff_offset = (i_offset < A_WIDTH'(3)) ? A_WIDTH'(3) : i_offset;
`else
    assign w_eff_offset = i_offset;
`endif
    assign w_rd_addr = r_wr_ptr - w_eff_offset;

    always_comb begin
        w_we = 1'b1;
        w_wa = r_clr_addr;
        w_wd = '0;
        if (r_state == RUN) begin
`ifdef SIG_ECHO_FEEDBACK_EN
            w_we = r_s2_valid;
            w_wa = r_s2_addr;
            w_wd = w_mix;
`else
            w_we = w_accept;
            w_wa = r_wr_ptr;
            w_wd = i_din;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[w_wa] <= w_wd;
        if (w_accept) r_rd_data <= r_mem[w_rd_addr];
    end

`ifdef SIG_ECHO_FEEDBACK_EN
    assign w_delayed = r_rd_data;
`else
    // Offset 0 would read the location being written on the same edge.
    assign w_delayed = r_s1_fwd ? r_s1_din : r_rd_data;
`endif

    assign w_shifted = $signed(r_s2_delayed) >>> r_s2_gain;
    assign w_sum     = {r_s2_din[D_WIDTH-1], r_s2_din} + {w_shifted[D_WIDTH-1], w_shifted};
    assign w_mix     = (w_sum[D_WIDTH] == w_sum[D_WIDTH-1]) ? w_sum[D_WIDTH-1:0] :
                       (w_sum[D_WIDTH] ? SAT_MIN : SAT_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s2_valid     <= 1'b0;
            o_out_valid    <= 1'b0;
            r_s1_din       <= '0;
            r_s1_gain      <= '0;
            r_s2_din       <= '0;
            r_s2_gain      <= '0;
            r_s2_delayed   <= '0;
            o_dout_delayed <= '0;
            o_dout_mix     <= '0;
`ifdef SIG_ECHO_FEEDBACK_EN
            r_s1_addr      <= '0;
            r_s2_addr      <= '0;
`else
            r_s1_fwd       <= 1'b0;
`endif
        end else begin
            r_s1_valid  <= w_accept;
            r_s2_valid  <= r_s1_valid && !w_clr_hit;
            o_out_valid <= r_s2_valid && !w_clr_hit;
            if (w_accept) begin
                r_s1_din  <= i_din;
                r_s1_gain <= i_gain_shift;
`ifdef SIG_ECHO_FEEDBACK_EN
                r_s1_addr <= r_wr_ptr;
`else
                r_s1_fwd  <= (i_offset == '0);
`endif
            end
            if (r_s1_valid) begin
                r_s2_din     <= r_s1_din;
                r_s2_gain    <= r_s1_gain;
                r_s2_delayed <= w_delayed;
`ifdef SIG_ECHO_FEEDBACK_EN
                r_s2_addr    <= r_s1_addr;
`endif
            end
            if (r_s2_valid && !w_clr_hit) begin
                o_dout_delayed <= r_s2_delayed;
                o_dout_mix     <= w_mix;
            end
        end
    end
endmodule
